// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH cycles per multiply, ready/valid in and out.
// Optional macro SEQ_MUL_SIGNED_EN adds a sgn port for two's-complement operands.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               sgn,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic            neg_in;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   result;
`ifdef SEQ_MUL_SIGNED_EN
  logic            neg;
`endif

  // Operand magnitudes and result sign as seen on the accept edge
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    if (sgn) begin
      a_mag  = a[WIDTH-1] ? WIDTH'(~a + WIDTH'(1)) : a;
      b_mag  = b[WIDTH-1] ? WIDTH'(~b + WIDTH'(1)) : b;
      neg_in = a[WIDTH-1] ^ b[WIDTH-1];
    end
`endif
  end

  // One shift-add step; result is what product loads on the final step
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : PW'(0));
    result   = acc_next;
`ifdef SEQ_MUL_SIGNED_EN
    if (neg) result = PW'(~acc_next + PW'(1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= CALC;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= {WIDTH'(0), a_mag};
            mplier   <= b_mag;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
            neg      <= neg_in;
`endif
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            product   <= result;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // neg_in only feeds the signed build
  logic unused_neg;
  assign unused_neg = neg_in;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=8 and WIDTH=16 instances).
// Signed vectors run only when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        iv, ir, ov, ordy, bsy;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
`ifdef SEQ_MUL_SIGNED_EN
  logic        sgn8;
`endif

  logic        iv16, ir16, ov16, or16, bsy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SEQ_MUL_SIGNED_EN
    .sgn       (sgn8),
`endif
    .in_valid  (iv),
    .in_ready  (ir),
    .a         (a8),
    .b         (b8),
    .out_valid (ov),
    .out_ready (ordy),
    .product   (p8),
    .busy      (bsy)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SEQ_MUL_SIGNED_EN
    .sgn       (1'b0),
`endif
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .out_valid (ov16),
    .out_ready (or16),
    .product   (p16),
    .busy      (bsy16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the 8-bit unit with out_ready high
  task automatic mul8(input logic [7:0] ta, input logic [7:0] tb_, input logic [15:0] exp,
                      input string tag);
    int n;
    ordy = 1'b1;
    n = 0;
    while (!ir && n < 50) begin tick(); n++; end
    check({tag, " ready"}, 64'(ir), 64'd1);
    a8 = ta; b8 = tb_; iv = 1'b1;
    tick();
    iv = 1'b0; a8 = ~ta; b8 = ~tb_;
    check({tag, " calc"}, {ir, bsy, ov}, 3'b010);
    n = 0;
    while (!ov && n < 50) begin tick(); n++; end
    check({tag, " latency"}, 64'(n), 64'd8);
    check({tag, " product"}, 64'(p8), 64'(exp));
    tick();
    check({tag, " idle"}, {ov, ir, bsy}, 3'b010);
  endtask

  initial begin
    int n;
    int nacc, acc0, acc1, first_ov;
    rst_n = 1'b0;
    iv = 1'b0; ordy = 1'b1; a8 = '0; b8 = '0;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0;
`ifdef SEQ_MUL_SIGNED_EN
    sgn8 = 1'b0;
`endif
    #23;
    check("reset flags", {ir, ov, bsy}, 3'b100);
    check("reset product", 64'(p8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=16 back-to-back with in_valid held high
    tick();
    a16 = 16'hFFFF; b16 = 16'h0002; iv16 = 1'b1;
    nacc = 0; acc0 = -1; acc1 = -1; first_ov = -1;
    for (int c = 0; c < 60; c++) begin
      if (ir16) begin
        if (nacc == 0) acc0 = c;
        else if (nacc == 1) acc1 = c;
        nacc++;
      end
      if (ov16 && first_ov < 0) begin
        first_ov = c;
        check("w16 product", 64'(p16), 64'h0001_FFFE);
        check("w16 busy", 64'(bsy16), 64'd1);
      end
      tick();
    end
    iv16 = 1'b0;
    check("w16 first accept", 64'(acc0), 64'd0);
    check("w16 issue interval", 64'(acc1 - acc0), 64'd18);
    check("w16 latency", 64'(first_ov - acc0), 64'd17);

    mul8(8'd13, 8'd11, 16'h008F, "13x11");
    mul8(8'd255, 8'd255, 16'hFE01, "255x255");
    mul8(8'd0, 8'd200, 16'h0000, "0x200");

    // Back-pressure: DONE held, in_valid ignored
    ordy = 1'b0;
    a8 = 8'd20; b8 = 8'd30; iv = 1'b1;
    tick();
    iv = 1'b0;
    n = 0;
    while (!ov && n < 50) begin tick(); n++; end
    check("bp latency", 64'(n), 64'd8);
    for (int k = 0; k < 5; k++) begin
      a8 = 8'd3; b8 = 8'd3; iv = k[0];
      tick();
      check("bp hold flags", {ov, ir, bsy}, 3'b101);
      check("bp hold product", 64'(p8), 64'd600);
    end
    iv = 1'b0; ordy = 1'b1;
    tick();
    check("bp release", {ov, ir, bsy}, 3'b010);
    check("bp product kept", 64'(p8), 64'd600);
    tick();
    check("bp no queued op", {ir, bsy}, 2'b10);

    // Asynchronous reset in the middle of CALC
    a8 = 8'd9; b8 = 8'd9; iv = 1'b1;
    tick();
    iv = 1'b0;
    tick(); tick(); tick();
    check("midcalc busy", 64'(bsy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midcalc reset flags", {ov, ir, bsy}, 3'b010);
    check("midcalc reset product", 64'(p8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mul8(8'd6, 8'd7, 16'd42, "6x7");

`ifdef SEQ_MUL_SIGNED_EN
    sgn8 = 1'b1;
    mul8(8'hFD, 8'd5, 16'hFFF1, "s -3x5");
    mul8(8'h80, 8'h80, 16'h4000, "s -128x-128");
    mul8(8'h80, 8'h7F, 16'hC080, "s -128x127");
    sgn8 = 1'b0;
    mul8(8'h80, 8'h80, 16'h4000, "u 0x80x0x80");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
